aes128_encrypt_iter: RTL and testbench



---
 rtl/aes128_encrypt_iter.sv | 176 +++++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter
//   Iterative AES-128 encryption engine. A registered state/round-key pair is
//   cycled through ROUNDS_PER_CYCLE chained round datapaths (each with its own
//   on-the-fly key expansion step) until all 10 rounds are done.
//
// Ports
//   CLK        clock, all state on the rising edge
//   RST        asynchronous, active-high reset
//   inValid    plaintext/key pair presented
//   inReady    engine accepts a pair this cycle
//   inputData  plaintext, bits [127:120] = byte 0, column-major
//   inputKey   cipher key, same byte order
//   outValid   ciphertext available
//   outReady   downstream consumes ciphertext
//   outputData ciphertext (zero whenever outValid is low)
//   busy       high while a block is in flight or waiting to be taken
module aes128_encrypt_iter #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inputData,
  input  logic [127:0] inputKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outputData,
  output logic         busy
);

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_param
      $error("aes128_encrypt_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  // Element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    // SubWord(RotWord(w3)): rotate bytes left by one, then substitute.
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [31:0]  col;
    logic [127:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(st[127-8*i -: 8]);
    // ShiftRows: row r of column c comes from column (c+r) mod 4.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      col = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      res[127-32*c -: 32] = last ? col : mix_col(col);
    end
    return res ^ rk;
  endfunction

  fsm_t         r_fsm, w_fsm_next;
  logic [127:0] r_state, r_key;
  logic [3:0]   r_round;
  logic         w_accept, w_final;

  logic [127:0] w_st  [ROUNDS_PER_CYCLE+1];
  logic [127:0] w_key [ROUNDS_PER_CYCLE+1];

  assign w_st[0]  = r_state;
  assign w_key[0] = r_key;

  genvar gi;
  generate
    for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
      logic [3:0] w_rnd;
      assign w_rnd        = r_round + 4'(gi);
      assign w_key[gi+1]  = next_key(w_key[gi], rcon(w_rnd));
      assign w_st[gi+1]   = enc_round(w_st[gi], w_key[gi+1], w_rnd == 4'd10);
    end
  endgenerate

  // The slice evaluated this cycle ends on round 10.
  assign w_final  = (r_round + 4'(ROUNDS_PER_CYCLE - 1)) == 4'd10;

  assign inReady    = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && outReady);
  assign w_accept   = inValid && inReady;
  assign outValid   = (r_fsm == S_DONE);
  assign outputData = outValid ? r_state : 128'h0;
  assign busy       = (r_fsm != S_IDLE);

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE:  if (w_accept) w_fsm_next = S_RUN;
      S_RUN:   if (w_final) w_fsm_next = S_DONE;
      S_DONE:  if (outReady) w_fsm_next = w_accept ? S_RUN : S_IDLE;
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fsm   <= S_IDLE;
      r_state <= '0;
      r_key   <= '0;
      r_round <= '0;
    end else begin
      r_fsm <= w_fsm_next;
      if (w_accept) begin
        r_state <= inputData ^ inputKey;
        r_key   <= inputKey;
        r_round <= 4'd1;
      end else if (r_fsm == S_RUN) begin
        r_state <= w_st[ROUNDS_PER_CYCLE];
        r_key   <= w_key[ROUNDS_PER_CYCLE];
        // Park at 10 once the last round is done so the counter never wraps.
        r_round <= w_final ? 4'd10 : r_round + 4'(ROUNDS_PER_CYCLE);
      end
    end
  end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Testbench for aes128_encrypt_iter: four instances (unroll 1, 2, 5, 10)
// sharing one clock and reset, driven with FIPS-197 vectors and random
// streams checked against an independent byte-oriented AES-128 model.
module tb_aes128_encrypt_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data  [4];
  logic [127:0] in_key   [4];
  logic [127:0] out_data [4];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tsbox [256];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      aes128_encrypt_iter #(
        .ROUNDS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10)
      ) dut (
        .CLK        (clk),
        .RST        (rst),
        .inValid    (in_valid[g]),
        .inReady    (in_ready[g]),
        .inputData  (in_data[g]),
        .inputKey   (in_key[g]),
        .outValid   (out_valid[g]),
        .outReady   (out_ready[g]),
        .outputData (out_data[g]),
        .busy       (busy[g])
      );
    end
  endgenerate

  function automatic int exp_lat(input int u);
    case (u)
      0:       return 11;
      1:       return 6;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      tsbox[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   tw [4];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tw[0] = tsbox[k[13]] ^ rc;
      tw[1] = tsbox[k[14]];
      tw[2] = tsbox[k[15]];
      tw[3] = tsbox[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ tw[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = tsbox[s[4*((c+w)%4)+w]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          if (r < 10)
            s[4*c+w] = gmul(t[4*c+w], 8'h02) ^ gmul(t[4*c+(w+1)%4], 8'h03)
                     ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
          else
            s[4*c+w] = t[4*c+w];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Starts in the cycle after acceptance; returns that cycle's distance from
  // the acceptance cycle at which outValid is first seen.
  task automatic wait_done(input int u, input bit scramble, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid[u] = 1'b0;
      if (scramble) begin
        in_data[u] = rand128();
        in_key[u]  = rand128();
      end
      lat++;
      #1;
    end while (!out_valid[u] && lat < 40);
  endtask

  task automatic run_block(input int u, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct, input bit scramble, input string tag);
    int n, lat;
    @(negedge clk);
    in_valid[u]  = 1'b1;
    in_data[u]   = pt;
    in_key[u]    = key;
    out_ready[u] = 1'b1;
    #1;
    n = 0;
    while (!in_ready[u] && n < 40) begin
      @(negedge clk); n++; #1;
    end
    check({tag, "_accept"}, 128'(in_ready[u]), 128'd1);
    wait_done(u, scramble, lat);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat(u)));
    check({tag, "_data"}, out_data[u], ct);
    check({tag, "_busy"}, 128'(busy[u]), 128'd1);
    @(negedge clk); #1;
    check({tag, "_valid_drop"}, 128'(out_valid[u]), 128'd0);
  endtask

  task automatic backpressure(input int u, input string tag);
    int lat;
    logic [127:0] held;
    @(negedge clk);
    in_valid[u] = 1'b1; in_data[u] = B_PT; in_key[u] = B_KEY; out_ready[u] = 1'b0;
    wait_done(u, 1'b0, lat);
    check({tag, "_first"}, out_data[u], B_CT);
    held = out_data[u];
    in_valid[u] = 1'b1; in_data[u] = C1_PT; in_key[u] = C1_KEY;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check({tag, "_hold_data"}, out_data[u], held);
      check({tag, "_hold_ready"}, 128'(in_ready[u]), 128'd0);
      check({tag, "_hold_valid"}, 128'(out_valid[u]), 128'd1);
    end
    @(negedge clk);
    out_ready[u] = 1'b1;
    #1;
    check({tag, "_release_ready"}, 128'(in_ready[u]), 128'd1);
    wait_done(u, 1'b0, lat);
    check({tag, "_second_latency"}, 128'(lat), 128'(exp_lat(u)));
    check({tag, "_second_data"}, out_data[u], C1_CT);
    @(negedge clk); #1;
    check({tag, "_second_drop"}, 128'(out_valid[u]), 128'd0);
  endtask

  task automatic stream(input int u, input string tag);
    logic [127:0] q [$];
    logic [127:0] k, p, e;
    int  sent, got, cyc;
    bit  acc;
    sent = 0; got = 0; cyc = 0; acc = 1'b0;
    in_valid[u] = 1'b0;
    while (got < 100 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid[u] = 1'b0;
      if (!in_valid[u] && sent < 100 && $urandom_range(0, 2) != 0) begin
        k = rand128(); p = rand128();
        in_key[u] = k; in_data[u] = p;
        q.push_back(aes_ref(k, p));
        in_valid[u] = 1'b1;
      end
      out_ready[u] = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid[u] && in_ready[u];
      if (acc) sent++;
      if (out_valid[u] && out_ready[u]) begin
        check({tag, "_pending"}, 128'(q.size() > 0), 128'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check({tag, "_data"}, out_data[u], e);
        end
        got++;
      end
    end
    check({tag, "_count"}, 128'(got), 128'd100);
    @(negedge clk);
    if (acc) in_valid[u] = 1'b0;
    out_ready[u] = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check({tag, "_tail_valid"}, 128'(out_valid[u]), 128'd0);
    check({tag, "_tail_queue"}, 128'(q.size()), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    for (int u = 0; u < 4; u++) begin
      in_data[u] = '0;
      in_key[u]  = '0;
    end
    build_sbox();
    #2;
    for (int u = 0; u < 4; u++) begin
      check("reset_inready", 128'(in_ready[u]), 128'd1);
      check("reset_outvalid", 128'(out_valid[u]), 128'd0);
      check("reset_outdata", out_data[u], 128'h0);
      check("reset_busy", 128'(busy[u]), 128'd0);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_block(0, C1_KEY, C1_PT, C1_CT, 1'b0, "c1_u1");
    run_block(0, B_KEY, B_PT, B_CT, 1'b0, "appb_u1");
    run_block(1, B_KEY, B_PT, B_CT, 1'b0, "appb_u2");
    run_block(2, B_KEY, B_PT, B_CT, 1'b0, "appb_u5");
    run_block(3, B_KEY, B_PT, B_CT, 1'b0, "appb_u10");

    run_block(0, B_KEY, B_PT, B_CT, 1'b1, "stable_u1");
    run_block(2, C1_KEY, C1_PT, C1_CT, 1'b1, "stable_u5");

    backpressure(0, "bp_u1");
    backpressure(3, "bp_u10");

    // Abort a block in round 5 with an asynchronous reset.
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = C1_PT; in_key[0] = C1_KEY; out_ready[0] = 1'b1;
    lat = 0;
    repeat (5) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
      lat++;
    end
    #1;
    check("midrun_busy_before", 128'(busy[0]), 128'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_inready", 128'(in_ready[0]), 128'd1);
    check("midrun_rst_outvalid", 128'(out_valid[0]), 128'd0);
    check("midrun_rst_outdata", out_data[0], 128'h0);
    check("midrun_rst_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block(0, C1_KEY, C1_PT, C1_CT, 1'b0, "after_rst");

    stream(0, "stream_u1");
    stream(3, "stream_u10");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
